// File: rtl/id_pkg.sv
// id_pkg: decode constants and the ID/EXE control bundle.
// Build option ID_WB_BYPASS_EN enables write-first register reads.
package id_pkg;

  localparam logic [1:0] MODE_ALU = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic       imm;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic logic cond_ok(
    input logic [3:0] cond,
    input logic [3:0] sr
  );
    logic n, z, c, v, ok;
    {n, z, c, v} = sr;
    case (cond)
      CC_EQ:   ok = z;
      CC_NE:   ok = !z;
      CC_CS:   ok = c;
      CC_CC:   ok = !c;
      CC_MI:   ok = n;
      CC_PL:   ok = !n;
      CC_VS:   ok = v;
      CC_VC:   ok = !v;
      CC_HI:   ok = c && !z;
      CC_LS:   ok = !c || z;
      CC_GE:   ok = (n == v);
      CC_LT:   ok = (n != v);
      CC_GT:   ok = !z && (n == v);
      CC_LE:   ok = z || (n != v);
      CC_AL:   ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic ctrl_t decode(
    input logic [31:0] ins,
    input logic [3:0]  sr
  );
    ctrl_t      c;
    logic [1:0] md;
    logic [3:0] op;
    md = ins[27:26];
    op = ins[24:21];
    c = '0;
    c.imm = ins[25];
    unique case (1'b1)
      md == MODE_ALU: begin
        c.wb_en = 1'b1;
        c.s = ins[20];
        case (op)
          OP_MOV: c.exe_cmd = EXE_MOV;
          OP_MVN: c.exe_cmd = EXE_MVN;
          OP_ADD: c.exe_cmd = EXE_ADD;
          OP_ADC: c.exe_cmd = EXE_ADC;
          OP_SUB: c.exe_cmd = EXE_SUB;
          OP_SBC: c.exe_cmd = EXE_SBC;
          OP_AND: c.exe_cmd = EXE_AND;
          OP_ORR: c.exe_cmd = EXE_ORR;
          OP_EOR: c.exe_cmd = EXE_EOR;
          OP_CMP: begin
            c.exe_cmd = EXE_SUB;
            c.wb_en = 1'b0;
          end
          OP_TST: begin
            c.exe_cmd = EXE_AND;
            c.wb_en = 1'b0;
          end
          default: begin
            c.wb_en = 1'b0;
            c.s = 1'b0;
          end
        endcase
      end
      md == MODE_MEM: begin
        c.exe_cmd = EXE_ADD;
        c.mem_r_en = ins[20];
        c.wb_en = ins[20];
        c.mem_w_en = !ins[20];
      end
      md == MODE_BR: c.b = 1'b1;
      default: ;
    endcase
    if (!cond_ok(ins[31:28], sr)) begin
      c.wb_en = 1'b0;
      c.mem_r_en = 1'b0;
      c.mem_w_en = 1'b0;
      c.b = 1'b0;
      c.s = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_register_file.sv
// register_file: 2 async read ports, 1 sync write port.
// ID_WB_BYPASS_EN: a same-cycle write is forwarded to the reads.
module register_file
  import id_pkg::*;
#(
  parameter int DW = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_regs [NREGS];
  logic          w_wr;

  assign w_wr = i_we && (int'(i_waddr) < NREGS);

  // Clear on reset, otherwise one in-range write per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports, optionally forwarding the pending write.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (int'(i_raddr1) < NREGS) o_rdata1 = r_regs[i_raddr1];
    if (int'(i_raddr2) < NREGS) o_rdata2 = r_regs[i_raddr2];
`ifdef ID_WB_BYPASS_EN
    if (w_wr && i_raddr1 == i_waddr) o_rdata1 = i_wdata;
    if (w_wr && i_raddr2 == i_waddr) o_rdata2 = i_wdata;
`endif
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: ARM-subset decode, register read, ID/EXE register.
// Build option ID_WB_BYPASS_EN: write-first register reads.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DW = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pc_in,
  input  logic [31:0]   instruction,
  input  logic          hazard,
  input  logic          flush,
  input  logic [3:0]    sr,
  input  logic          wb_wb_en,
  input  logic [AW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic          out_valid,
  output logic          wb_en,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic          b,
  output logic          s,
  output logic          imm,
  output logic [3:0]    exe_cmd,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] value_rn,
  output logic [DW-1:0] value_rm,
  output logic [11:0]   shift_operand,
  output logic [23:0]   imm_signed_24,
  output logic [AW-1:0] dest,
  output logic          two_src,
  output logic [AW-1:0] src_1,
  output logic [AW-1:0] src_2
);

  ctrl_t         w_ctrl;
  ctrl_t         r_ctrl;
  logic          w_xfer;
  logic          w_str;
  logic [DW-1:0] w_rn;
  logic [DW-1:0] w_rm;

  assign in_ready = !hazard;
  assign w_xfer = in_valid && in_ready;
  assign w_str = (instruction[27:26] == MODE_MEM)
               && !instruction[20];
  assign two_src = (!instruction[25]
               && instruction[27:26] == MODE_ALU) || w_str;
  assign src_1 = AW'(instruction[19:16]);
  assign src_2 = w_str ? AW'(instruction[15:12])
                       : AW'(instruction[3:0]);
  assign w_ctrl = decode(instruction, sr);

  register_file #(
    .DW(DW),
    .NREGS(NREGS)
  ) u_rf (
    .clk(clk),
    .rst(rst),
    .i_we(wb_wb_en),
    .i_waddr(wb_dest),
    .i_wdata(wb_value),
    .i_raddr1(src_1),
    .i_raddr2(src_2),
    .o_rdata1(w_rn),
    .o_rdata2(w_rm)
  );

  // ID/EXE register: flush/idle/stall insert a bubble, data holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      r_ctrl <= '0;
      pc <= '0;
      value_rn <= '0;
      value_rm <= '0;
      shift_operand <= '0;
      imm_signed_24 <= '0;
      dest <= '0;
    end else if (flush || !w_xfer) begin
      out_valid <= 1'b0;
      r_ctrl <= '0;
    end else begin
      out_valid <= 1'b1;
      r_ctrl <= w_ctrl;
      pc <= pc_in;
      value_rn <= w_rn;
      value_rm <= w_rm;
      shift_operand <= instruction[11:0];
      imm_signed_24 <= instruction[23:0];
      dest <= AW'(instruction[15:12]);
    end
  end

  assign wb_en = r_ctrl.wb_en;
  assign mem_r_en = r_ctrl.mem_r_en;
  assign mem_w_en = r_ctrl.mem_w_en;
  assign b = r_ctrl.b;
  assign s = r_ctrl.s;
  assign imm = r_ctrl.imm;
  assign exe_cmd = r_ctrl.exe_cmd;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: vector table, directed corner cases and a
// random run against a behavioural model of the ID stage.
module tb_id_stage_pipe;

  localparam int DW = 64;
  localparam int NREGS = 16;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, hazard, flush, wb_wb_en;
  logic out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
  logic two_src;
  logic [DW-1:0] pc_in, wb_value, pc, value_rn, value_rm;
  logic [31:0] instruction;
  logic [3:0] sr, wb_dest, exe_cmd, dest, src_1, src_2;
  logic [11:0] shift_operand;
  logic [23:0] imm_signed_24;

  int n_cmp = 0;
  int n_bad = 0;
  bit bypass;

  // ctl = {wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd}
  typedef struct {
    logic          ov;
    logic [9:0]    ctl;
    logic [DW-1:0] pc, rn, rm;
    logic [11:0]   sh;
    logic [23:0]   i24;
    logic [3:0]    dest;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  f;
    logic [9:0]  ctl;
  } vec_t;

  exp_t e;
  logic [DW-1:0] mregs [16];
  int cmd_of [16];
  vec_t tv [20];

  always #5 clk = ~clk;

  id_stage_pipe #(.DW(DW), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction(instruction),
    .hazard(hazard), .flush(flush), .sr(sr),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .wb_value(wb_value),
    .out_valid(out_valid), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .b(b), .s(s), .imm(imm), .exe_cmd(exe_cmd),
    .pc(pc), .value_rn(value_rn), .value_rm(value_rm),
    .shift_operand(shift_operand),
    .imm_signed_24(imm_signed_24), .dest(dest),
    .two_src(two_src), .src_1(src_1), .src_2(src_2)
  );

  function automatic void chk(input string nm,
                              input logic [63:0] a,
                              input logic [63:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, a, x,
               $time);
    end
  endfunction

  // ARM conditions: pairs of a base test and its inverse.
  function automatic bit ref_cond(input logic [3:0] c,
                                  input logic [3:0] f);
    bit n, z, cf, v, r;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: return c == 4'hE;
    endcase
    return c[0] ? !r : r;
  endfunction

  function automatic logic [9:0] ref_ctl(input logic [31:0] ins,
                                         input logic [3:0] f);
    logic wb, mr, mw, br, sf;
    logic [3:0] cmd;
    int k;
    {wb, mr, mw, br, sf} = '0;
    cmd = '0;
    k = cmd_of[ins[24:21]];
    case (ins[27:26])
      2'd0: if (k >= 0) begin
        cmd = 4'(k);
        wb = !(ins[24:21] == 4'd10 || ins[24:21] == 4'd8);
        sf = ins[20];
      end
      2'd1: begin
        cmd = 4'd2;
        if (ins[20]) {mr, wb} = 2'b11;
        else mw = 1'b1;
      end
      2'd2: br = 1'b1;
      default: ;
    endcase
    if (!ref_cond(ins[31:28], f)) {wb, mr, mw, br, sf} = '0;
    return {wb, mr, mw, br, sf, ins[25], cmd};
  endfunction

  function automatic logic [DW-1:0] rd(input logic [3:0] a);
    if (bypass && wb_wb_en && wb_dest == a) return wb_value;
    return mregs[a];
  endfunction

  // One clock: check combinational outputs, predict, clock, compare.
  task automatic cyc();
    exp_t n;
    logic [3:0] ra, rbb;
    bit str;
    #1;
    str = instruction[27:26] == 2'd1 && !instruction[20];
    ra = instruction[19:16];
    rbb = str ? instruction[15:12] : instruction[3:0];
    chk("comb", {in_ready, two_src, src_1, src_2},
        {!hazard,
         (!instruction[25] && instruction[27:26] == 2'd0) || str,
         ra, rbb});
    n = e;
    if (!rst) begin
      n = '{default: '0};
      foreach (mregs[i]) mregs[i] = '0;
    end else begin
      n.ov = 1'b0;
      n.ctl = '0;
      if (!flush && in_valid && !hazard) begin
        n.ov = 1'b1;
        n.ctl = ref_ctl(instruction, sr);
        n.pc = pc_in;
        n.rn = rd(ra);
        n.rm = rd(rbb);
        n.sh = instruction[11:0];
        n.i24 = instruction[23:0];
        n.dest = instruction[15:12];
      end
      if (wb_wb_en) mregs[wb_dest] = wb_value;
    end
    @(posedge clk);
    #1;
    e = n;
    chk("ctl", {out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm,
                exe_cmd, dest}, {e.ov, e.ctl, e.dest});
    chk("pc", pc, e.pc);
    chk("rn", value_rn, e.rn);
    chk("rm", value_rm, e.rm);
    chk("fields", {shift_operand, imm_signed_24}, {e.sh, e.i24});
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm,
             exe_cmd, dest, shift_operand, imm_signed_24}, 64'd0);
    chk({nm, "_data"}, pc | value_rn | value_rm, 64'd0);
  endtask

  initial begin
    foreach (cmd_of[i]) cmd_of[i] = -1;
    cmd_of[13] = 1; cmd_of[15] = 9; cmd_of[4] = 2;
    cmd_of[5] = 3;  cmd_of[2] = 4;  cmd_of[6] = 5;
    cmd_of[0] = 6;  cmd_of[12] = 7; cmd_of[1] = 8;
    cmd_of[10] = 4; cmd_of[8] = 6;
`ifdef ID_WB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    tv[0]  = '{32'hE0821003, 4'h0, 10'b100000_0010};
    tv[1]  = '{32'h01A01002, 4'h0, 10'b000000_0001};
    tv[2]  = '{32'h01A01002, 4'h4, 10'b100000_0001};
    tv[3]  = '{32'hE1E01002, 4'h0, 10'b100000_1001};
    tv[4]  = '{32'hE1510002, 4'h0, 10'b000010_0100};
    tv[5]  = '{32'hE1110002, 4'h0, 10'b000010_0110};
    tv[6]  = '{32'hE2421005, 4'h0, 10'b100001_0100};
    tv[7]  = '{32'hE4121004, 4'h0, 10'b110000_0010};
    tv[8]  = '{32'hE4021004, 4'h0, 10'b001000_0010};
    tv[9]  = '{32'hEA000010, 4'h0, 10'b000101_0000};
    tv[10] = '{32'hE0621003, 4'h0, 10'b000000_0000};
    tv[11] = '{32'hF0821003, 4'h0, 10'b000000_0010};
    tv[12] = '{32'h1A000010, 4'h4, 10'b000001_0000};
    tv[13] = '{32'hC0921003, 4'h9, 10'b100010_0010};
    tv[14] = '{32'hB0A21003, 4'h8, 10'b100000_0011};
    tv[15] = '{32'h81821003, 4'h2, 10'b100000_0111};
    tv[16] = '{32'h20221003, 4'h0, 10'b000000_1000};
    tv[17] = '{32'h90C21003, 4'h4, 10'b100000_0101};
    tv[18] = '{32'h60021003, 4'h1, 10'b100000_0110};
    tv[19] = '{32'hEC000000, 4'h0, 10'b000000_0000};

    rst = 1'b0; in_valid = 1'b0; hazard = 1'b0; flush = 1'b0;
    wb_wb_en = 1'b0; wb_dest = '0; wb_value = '0; sr = '0;
    instruction = '0; pc_in = '0;
    foreach (mregs[i]) mregs[i] = '0;
    e = '{default: '0};
    cyc();
    chk_zero("reset");
    rst = 1'b1;

    // ADD R1,R2,R3 with R2=5, R3=7
    wb_wb_en = 1'b1; wb_dest = 4'd2; wb_value = 64'd5; cyc();
    wb_dest = 4'd3; wb_value = 64'd7; cyc();
    wb_wb_en = 1'b0;
    instruction = 32'hE0821003; in_valid = 1'b1;
    pc_in = 64'h104;
    cyc();
    chk("add_ctl", {out_valid, wb_en, exe_cmd, dest},
        {1'b1, 1'b1, 4'b0010, 4'd1});
    chk("add_rn", value_rn, 64'd5);
    chk("add_rm", value_rm, 64'd7);
    chk("add_pc", pc, 64'h104);

    foreach (tv[i]) begin
      instruction = tv[i].ins; sr = tv[i].f;
      pc_in = 64'(i);
      cyc();
      chk($sformatf("vec%0d", i),
          {out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm,
           exe_cmd}, {1'b1, tv[i].ctl});
    end
    sr = '0;

    // Two-cycle stall on a valid LDR
    instruction = 32'hE4121004; hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("hz_ready", in_ready, 1'b0);
      chk("hz_bubble", {out_valid, wb_en, mem_r_en, mem_w_en,
                        b, s, imm, exe_cmd}, 64'd0);
    end
    hazard = 1'b0;
    cyc();
    chk("hz_ldr", {out_valid, mem_r_en, wb_en}, 3'b111);

    // Flush beats hazard and transfer
    flush = 1'b1; hazard = 1'b1;
    cyc();
    chk("flush", {out_valid, wb_en, mem_r_en, mem_w_en,
                  b, s, imm, exe_cmd}, 64'd0);
    flush = 1'b0; hazard = 1'b0;

    // Read during write of Rn=4
    in_valid = 1'b0;
    wb_wb_en = 1'b1; wb_dest = 4'd4; wb_value = 64'h1111;
    cyc();
    instruction = 32'hE0841003; in_valid = 1'b1;
    wb_value = 64'hDEAD;
    cyc();
    chk("rd_wr", value_rn, bypass ? 64'hDEAD : 64'h1111);
    wb_wb_en = 1'b0;
    cyc();
    chk("rd_after", value_rn, 64'hDEAD);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      instruction = $urandom;
      if ($urandom_range(1, 0) == 1) instruction[31:28] = 4'hE;
      sr = 4'($urandom);
      pc_in = {$urandom, $urandom};
      in_valid = ($urandom_range(4, 0) != 0);
      hazard = ($urandom_range(4, 0) == 0);
      flush = ($urandom_range(7, 0) == 0);
      rst = ($urandom_range(59, 0) != 0);
      wb_wb_en = $urandom_range(1, 0) == 1;
      wb_dest = 4'($urandom);
      wb_value = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b1; flush = 1'b0; hazard = 1'b0; sr = '0;

    // Reset in the middle of a stall
    wb_wb_en = 1'b1; wb_dest = 4'd7; wb_value = 64'h77;
    instruction = 32'hE0821003; in_valid = 1'b1;
    cyc();
    wb_wb_en = 1'b0; instruction = 32'hE4121004;
    hazard = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk_zero("rst_stall");
    rst = 1'b1; hazard = 1'b0;
    for (int i = 0; i < 16; i++) begin
      instruction = 32'hE0800000 | (32'(i) << 16) | 32'(i);
      cyc();
      chk($sformatf("clr_r%0d", i), {value_rn, value_rm}, 0);
      if (i == 0) chk("post_rst", {out_valid, wb_en, exe_cmd},
                      {1'b1, 1'b1, 4'b0010});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameter DW, default 32, datapath width of PC, register values and write-back value (legal: 32 or 64).
REQ-002 Parameter NREGS, default 16, number of architectural registers; AW = clog2(NREGS); 4-bit register fields are zero-extended to AW.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  instruction/pc_in valid from IF; in_ready  out  1  ID accepts this cycle.
REQ-006 pc_in  in  DW  PC+4 of instruction; instruction  in  32  ARM encoding.
REQ-007 hazard  in  1  stall request from the hazard detection unit; flush  in  1  branch taken in EXE.
REQ-008 sr  in  4  {N,Z,C,V} status flags.
REQ-009 wb_wb_en  in  1, wb_dest  in  AW, wb_value  in  DW  register-file write port.
REQ-010 out_valid  out  1  ID/EXE register holds a live instruction.
REQ-011 wb_en, mem_r_en, mem_w_en, b, s, imm  out  1 each; exe_cmd  out  4; pc  out  DW; value_rn, value_rm  out  DW; shift_operand  out  12; imm_signed_24  out  24; dest  out  AW; all registered.
REQ-012 two_src  out  1, src_1, src_2  out  AW  combinational from instruction, for hazard detection.

Function
REQ-013 Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_operand[11:0], imm_24[23:0].
REQ-014 Mode 00 exe_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wb_en=1 except CMP/TST; other opcodes decode as NOP (all enables 0).
REQ-015 Mode 01: S=1 LDR (mem_r_en=1, wb_en=1), S=0 STR (mem_w_en=1); exe_cmd=0010. Mode 10: b=1, exe_cmd don't-care (0000).
REQ-016 cond EQ..LE evaluated against sr per ARM; AL=1110 true; 1111 false; failed cond clears wb_en, mem_r_en, mem_w_en, b, s.
REQ-017 src_1=Rn; src_2=Rd if mem_w_en else Rm[3:0]; two_src=1 when (I=0 and mode 00) or STR.
REQ-018 in_ready = !hazard; transfer when in_valid && in_ready.
REQ-019 Each cycle: flush -> out_valid<=0 and all control outputs <=0 (flush beats hazard and transfer); else transfer -> load decoded bundle, out_valid<=1; else hazard -> control outputs <=0, out_valid<=0 (bubble), data fields hold; else out_valid<=0 with controls 0.
REQ-020 Latency: instruction accepted at edge N appears on outputs after edge N+1... i.e. one cycle.
REQ-021 Register file written on rising edge when wb_wb_en; writes to wb_dest >= NREGS ignored.
REQ-022 Read of a register written the same cycle returns wb_value (write-first) only when bypass enabled (REQ-026).

Reset
REQ-023 rst=0 at edge: out_valid and every registered output <=0, all NREGS registers <=0.
REQ-024 Reset mid-stall or mid-flush discards the in-flight instruction; first accepted instruction after reset is decoded normally.

Configuration
REQ-025 Macro ID_WB_BYPASS_EN selects read-during-write behaviour.
REQ-026 Defined: value_rn/value_rm take wb_value when wb_wb_en and wb_dest equals the read address. Undefined: old register contents captured; WB must precede by one cycle.

Structure
REQ-027 Shared package id_pkg: opcode, mode and condition constants, exe_cmd encodings, decoded-bundle struct.
REQ-028 Sub-module register_file (parameters DW, NREGS; two read ports, one write port, bypass under macro).

Verification
REQ-029 ADD R1,R2,R3 (0xE0821003), R2=5,R3=7 -> next cycle exe_cmd=0010, wb_en=1, dest=1, value_rn=5, value_rm=7, out_valid=1.
REQ-030 MOVEQ with sr=0000 -> out_valid=1, wb_en=0; with sr=0100 -> wb_en=1, exe_cmd=0001.
REQ-031 hazard=1 for 2 cycles with valid LDR -> in_ready=0, two bubbles (controls 0), LDR emitted after hazard drops, mem_r_en=1.
REQ-032 flush=1 with hazard=1 and in_valid=1 -> out_valid=0, all controls 0 next cycle.
REQ-033 wb_wb_en=1, wb_dest=4, wb_value=0xDEAD while decoding Rn=4 -> value_rn=0xDEAD with ID_WB_BYPASS_EN, old value without.
REQ-034 rst=0 during stall, DW=64 -> all outputs 0, R0..R15 read 0 afterwards.
